lorenz_dac_spi: RTL and testbench
=================================

LORENZ_DAC_SPI -- requirements
Module: lorenz_dac_spi

Interface
REQ-001 SHALL have parameter Width, default 32, meaning state-variable word width (signed fixed point, 21 fractional bits).
REQ-002 SHALL have parameter Shift, default 14, meaning arithmetic right shift from fixed point to DAC counts (1.0 -> 128 counts).
REQ-003 SHALL have parameter Decim, default 1000, meaning accepted samples per DAC update (>=1).
REQ-004 SHALL have parameter ClkDiv, default 4, meaning clk_i cycles per SCLK half period (>=1).
REQ-005 SHALL have clk_i  in  1  system clock; single clock domain; all logic on rising edge.
REQ-006 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have en_i  in  1  enable; low holds the decimator and blocks new captures.
REQ-008 SHALL have valid_i  in  1  one-cycle strobe marking a new oscillator iteration on xn_i/yn_i/zn_i.
REQ-009 SHALL have xn_i, yn_i, zn_i  in  Width each  oscillator state, signed two's complement.
REQ-010 SHALL have sel_i  in  1  channel B source: 0 = yn_i, 1 = zn_i; sampled at capture.
REQ-011 SHALL have sclk_o  out  1  SPI clock, mode 0, idle low.
REQ-012 SHALL have cs_n_o  out  1  SPI chip select, active low.
REQ-013 SHALL have mosi_o  out  1  SPI data, MSB first.
REQ-014 SHALL have busy_o  out  1  high whenever FSM is not IDLE.
REQ-015 SHALL have overrun_o  out  1  sticky flag: decimated sample arrived while busy.

Function
REQ-016 Decimator SHALL count valid_i pulses while en_i high; on the pulse that brings the count to Decim it SHALL wrap to 0 and raise an internal capture request.
REQ-017 Capture request in IDLE SHALL latch channel A = xn_i and channel B = (sel_i ? zn_i : yn_i) on that same edge; request while busy SHALL drop the sample and set overrun_o.
REQ-018 Conversion: code = (v >>> Shift) + 2048, saturated to [0, 4095]; computed on full Width, no wraparound.
REQ-019 Frame SHALL be 16 bits: [15] channel (0 = A, 1 = B), [14] BUF = 0, [13] GA_n = 1, [12] SHDN_n = 1, [11:0] code.
REQ-020 FSM states IDLE -> LOAD -> SHIFT -> GAP -> (LOAD for channel B | IDLE after channel B).
REQ-021 LOAD: one cycle; cs_n_o goes low, mosi_o = bit 15.
REQ-022 SHIFT: sclk_o toggles every ClkDiv cycles; mosi_o changes only on falling sclk_o; exactly 16 rising edges per frame.
REQ-023 After the 16th falling edge: cs_n_o goes high, sclk_o low, and GAP holds them for ClkDiv cycles.
REQ-024 First cs_n_o falling edge SHALL occur the cycle after capture; a full update lasts 2*(1 + 32*ClkDiv + ClkDiv) cycles.
REQ-025 Inputs SHALL be ignored outside capture; en_i deassertion mid-update SHALL let the update finish.
REQ-026 Simultaneous capture request and return to IDLE SHALL count as busy (overrun).

Reset
REQ-027 rst_i SHALL, on the next edge, force IDLE, sclk_o = 0, cs_n_o = 1, mosi_o = 0, busy_o = 0, overrun_o = 0, and decimator count = 0, including mid-frame.

Structure
REQ-028 The frame field positions, the DAC midscale (2048) and full-scale (4095) constants, and the FSM state encoding SHALL live in a shared package, lorenz_pkg.
REQ-029 The saturating fixed-point to code conversion SHALL be one sub-module, fx_to_dac_code, instantiated twice (A, B).

Verification
REQ-030 Decim=1, xn_i=0x00200000 (1.0), sel_i=0, yn_i=0 -> frames 0x3880 then 0xB800.
REQ-031 xn_i=-20.0 (0xFD800000), sel_i=1, zn_i=40.0 (0x05000000) -> frames 0x3000 (saturated low) then 0xBFFF (saturated high).
REQ-032 Decim=4, valid_i every 2 cycles -> cs_n_o falls only after the 4th, 8th, ... pulse; count wraps to 0.
REQ-033 Decim=1, valid_i every 2 cycles, ClkDiv=4 -> overrun_o set on the second pulse and stays high; the first update completes unchanged.
REQ-034 rst_i asserted at bit 7 of frame A -> next cycle cs_n_o=1, sclk_o=0, busy_o=0; after release, the next capture starts a clean frame.
REQ-035 Mode-0 checker on every frame: mosi_o stable for the whole cycle around each sclk_o rise; exactly 16 rises per cs_n_o low window; GAP >= ClkDiv cycles.

Source files
------------

// File: rtl/lorenz_pkg.sv
// Shared frame layout, DAC code constants and FSM encoding for the Lorenz DAC SPI block.
package lorenz_pkg;

  localparam int unsigned FrameW   = 16;
  localparam int unsigned CodeW    = 12;

  // Frame field positions
  localparam int unsigned BitChan  = 15;
  localparam int unsigned BitBuf   = 14;
  localparam int unsigned BitGaN   = 13;
  localparam int unsigned BitShdnN = 12;

  localparam int unsigned DacMid   = 2048;
  localparam int unsigned DacFull  = 4095;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StGap   = 2'd3
  } dac_state_e;

  // Build a DAC command word: unbuffered, 1x gain, output active.
  function automatic logic [FrameW-1:0] make_frame(input logic chan,
                                                   input logic [CodeW-1:0] code);
    logic [FrameW-1:0] f;
    f              = '0;
    f[BitChan]     = chan;
    f[BitBuf]      = 1'b0;
    f[BitGaN]      = 1'b1;
    f[BitShdnN]    = 1'b1;
    f[CodeW-1:0]   = code;
    return f;
  endfunction

endpackage

// File: rtl/fx_to_dac_code.sv
// Signed fixed-point to 12-bit offset-binary DAC code with saturation.
module fx_to_dac_code
  import lorenz_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Shift = 14
) (
  input  logic [Width-1:0] value_i,
  output logic [CodeW-1:0] code_o
);

  localparam logic signed [Width:0] Mid  = (Width + 1)'(DacMid);
  localparam logic signed [Width:0] Full = (Width + 1)'(DacFull);

  logic signed [Width-1:0] shifted;
  logic signed [Width:0]   sum;

  // One extra bit of headroom so the midscale offset can never wrap.
  always_comb begin
    shifted = $signed(value_i) >>> Shift;
    sum     = $signed({shifted[Width-1], shifted}) + Mid;
    if (sum[Width]) begin
      code_o = '0;
    end else if (sum > Full) begin
      code_o = CodeW'(DacFull);
    end else begin
      code_o = sum[CodeW-1:0];
    end
  end

endmodule

// File: rtl/lorenz_dac_spi.sv
// Decimates Lorenz oscillator samples and ships two channels to a 12-bit SPI DAC (mode 0).
module lorenz_dac_spi
  import lorenz_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned Shift  = 14,
  parameter int unsigned Decim  = 1000,
  parameter int unsigned ClkDiv = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [Width-1:0] xn_i,
  input  logic [Width-1:0] yn_i,
  input  logic [Width-1:0] zn_i,
  input  logic             sel_i,
  output logic             sclk_o,
  output logic             cs_n_o,
  output logic             mosi_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int unsigned     CntW     = (Decim > 1) ? $clog2(Decim) : 1;
  localparam int unsigned     DivW     = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] DecLast  = CntW'(Decim - 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(ClkDiv - 1);
  localparam logic [4:0]      LastHalf = 5'd31;

  dac_state_e        state_q, state_d;
  logic [CntW-1:0]   dec_q, dec_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [4:0]        half_q, half_d;
  logic [FrameW-1:0] shreg_q, shreg_d;
  logic [FrameW-1:0] frame_b_q, frame_b_d;
  logic              chan_q, chan_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic              cap_req;
  logic [Width-1:0]  chan_b_src;
  logic [CodeW-1:0]  code_a, code_b;

  assign chan_b_src = sel_i ? zn_i : yn_i;

  fx_to_dac_code #(
    .Width (Width),
    .Shift (Shift)
  ) u_conv_a (
    .value_i (xn_i),
    .code_o  (code_a)
  );

  fx_to_dac_code #(
    .Width (Width),
    .Shift (Shift)
  ) u_conv_b (
    .value_i (chan_b_src),
    .code_o  (code_b)
  );

  // Decimator: every Decim-th enabled strobe raises a capture request.
  always_comb begin
    dec_d   = dec_q;
    cap_req = 1'b0;
    if (en_i && valid_i) begin
      if (dec_q == DecLast) begin
        dec_d   = '0;
        cap_req = 1'b1;
      end else begin
        dec_d = dec_q + 1'b1;
      end
    end
  end

  // Frame sequencer next-state; outputs are registered decodes of the next state.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    shreg_d   = shreg_q;
    frame_b_d = frame_b_q;
    chan_d    = chan_q;
    sclk_d    = sclk_q;
    ovr_d     = ovr_q;

    // A request in any non-idle state, including the final GAP cycle, is dropped.
    if (cap_req && (state_q != StIdle)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (cap_req) begin
          state_d   = StLoad;
          shreg_d   = make_frame(1'b0, code_a);
          frame_b_d = make_frame(1'b1, code_b);
          chan_d    = 1'b0;
          sclk_d    = 1'b0;
        end
      end
      StLoad: begin
        state_d = StShift;
        div_d   = '0;
        half_d  = '0;
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          half_d = half_q + 5'd1;
          if (sclk_q) begin
            // Falling edge: advance data, or close the frame after the 16th.
            if (half_q == LastHalf) begin
              state_d = StGap;
              sclk_d  = 1'b0;
            end else begin
              shreg_d = {shreg_q[FrameW-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!chan_q) begin
            state_d = StLoad;
            shreg_d = frame_b_q;
            chan_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    cs_n_d = !((state_d == StLoad) || (state_d == StShift));
    mosi_d = cs_n_d ? 1'b0 : shreg_d[FrameW-1];
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; synchronous reset also aborts a frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      dec_q     <= '0;
      div_q     <= '0;
      half_q    <= '0;
      shreg_q   <= '0;
      frame_b_q <= '0;
      chan_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dec_q     <= dec_d;
      div_q     <= div_d;
      half_q    <= half_d;
      shreg_q   <= shreg_d;
      frame_b_q <= frame_b_d;
      chan_q    <= chan_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign cs_n_o    = cs_n_q;
  assign mosi_o    = mosi_q;
  assign busy_o    = busy_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_lorenz_dac_spi.sv
// Directed bench for lorenz_dac_spi: frames, saturation, decimation, overrun, reset, mode 0.
module tb_lorenz_dac_spi;

  localparam int unsigned ClkDivA = 4;
  localparam int unsigned ClkDivB = 1;
  localparam int          UpdA    = 2 * (1 + 33 * ClkDivA);
  localparam int          UpdB    = 2 * (1 + 33 * ClkDivB);
  localparam int          Limit   = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] xn = '0, yn = '0, zn = '0;
  logic        sclk_a, cs_n_a, mosi_a, busy_a, ovr_a;
  logic        sclk_b, cs_n_b, mosi_b, busy_b, ovr_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lorenz_dac_spi #(.Width(32), .Shift(14), .Decim(1), .ClkDiv(ClkDivA)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .valid_i(valid),
    .xn_i(xn), .yn_i(yn), .zn_i(zn), .sel_i(sel),
    .sclk_o(sclk_a), .cs_n_o(cs_n_a), .mosi_o(mosi_a), .busy_o(busy_a), .overrun_o(ovr_a)
  );

  lorenz_dac_spi #(.Width(32), .Shift(14), .Decim(4), .ClkDiv(ClkDivB)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .valid_i(valid),
    .xn_i(xn), .yn_i(yn), .zn_i(zn), .sel_i(sel),
    .sclk_o(sclk_b), .cs_n_o(cs_n_b), .mosi_o(mosi_b), .busy_o(busy_b), .overrun_o(ovr_b)
  );

  // Serial monitor on dut_a: collects frames on sclk rises and records mode-0 violations.
  logic        p_sclk = 1'b0, p_mosi = 1'b0, p_cs_n = 1'b1;
  logic [15:0] acc = '0;
  int          rises = 0, gap = 0, mode0_bad = 0, gap_bad = 0;
  bit          seen = 0, aborted = 0;
  logic [15:0] frames[$];
  int          frame_rises[$];

  always @(negedge clk) begin
    if (p_cs_n && !cs_n_a) begin
      if (seen && gap < int'(ClkDivA)) gap_bad++;
      rises   = 0;
      acc     = '0;
      aborted = 0;
    end
    if (rst) begin
      aborted = 1;
      seen    = 0;
    end
    if (!cs_n_a && !p_sclk && sclk_a) begin
      rises++;
      acc = {acc[14:0], mosi_a};
      if (mosi_a !== p_mosi) mode0_bad++;
    end
    if (!cs_n_a && !p_cs_n && (mosi_a !== p_mosi) && !(p_sclk && !sclk_a)) mode0_bad++;
    if (cs_n_a && sclk_a) mode0_bad++;
    if (!p_cs_n && cs_n_a) begin
      if (!aborted) begin
        frames.push_back(acc);
        frame_rises.push_back(rises);
        seen = 1;
      end
      gap = 0;
    end
    if (cs_n_a) gap++;
    p_sclk = sclk_a;
    p_mosi = mosi_a;
    p_cs_n = cs_n_a;
  end

  // One-cycle strobe; returns 1 ns after the capturing edge.
  task automatic pulse(input logic e);
    @(posedge clk); #1;
    en    = e;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    en    = 1'b1;
  endtask

  // Called at a negedge; counts negedges with busy high, capped at Limit.
  task automatic wait_idle(input bit which_b, output int n);
    n = 0;
    while (((which_b ? busy_b : busy_a) === 1'b1) && n < Limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cs_n_a !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n_a); end
    n_cmp++; if (sclk_a !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", sclk_a); end
    n_cmp++; if (mosi_a !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (ovr_a !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", ovr_a); end
    n_cmp++; if (cs_n_b !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n_b: got %b want 1", cs_n_b); end
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_frames();
    int n;
    logic [15:0] exp [2];
    exp = '{16'h3880, 16'hB800};
    frames.delete(); frame_rises.delete();
    xn = 32'h0020_0000; yn = 32'h0; zn = 32'h0123_4567; sel = 1'b0;
    pulse(1'b1);
    // Inputs change and enable drops mid-update; neither may disturb the update.
    xn = 32'h7FFF_FFFF; yn = 32'h8000_0000; sel = 1'b1; en = 1'b0;
    @(negedge clk);
    n_cmp++; if (cs_n_a !== 1'b0) begin n_bad++; $display("FAIL frames_cs_fall: got %b want 0", cs_n_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL frames_busy: got %b want 1", busy_a); end
    wait_idle(1'b0, n);
    n_cmp++; if (n != UpdA) begin n_bad++; $display("FAIL frames_len: got %0d want %0d", n, UpdA); end
    n_cmp++; if (frames.size() != 2) begin n_bad++; $display("FAIL frames_count: got %0d want 2", frames.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < frames.size()) begin
        n_cmp++; if (frames[i] !== exp[i]) begin n_bad++; $display("FAIL frames_word%0d: got %h want %h", i, frames[i], exp[i]); end
        n_cmp++; if (frame_rises[i] != 16) begin n_bad++; $display("FAIL frames_rises%0d: got %0d want 16", i, frame_rises[i]); end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_saturate();
    int n;
    logic [15:0] exp [2];
    exp = '{16'h3000, 16'hBFFF};
    frames.delete(); frame_rises.delete();
    xn = 32'hFD80_0000; yn = 32'h0020_0000; zn = 32'h0500_0000; sel = 1'b1;
    pulse(1'b1);
    @(negedge clk);
    wait_idle(1'b0, n);
    n_cmp++; if (n != UpdA) begin n_bad++; $display("FAIL sat_len: got %0d want %0d", n, UpdA); end
    n_cmp++; if (frames.size() != 2) begin n_bad++; $display("FAIL sat_count: got %0d want 2", frames.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < frames.size()) begin
        n_cmp++; if (frames[i] !== exp[i]) begin n_bad++; $display("FAIL sat_word%0d: got %h want %h", i, frames[i], exp[i]); end
      end
    end
  endtask

  task automatic test_overrun();
    int n;
    logic [15:0] exp [2];
    exp = '{16'h3880, 16'hB800};
    frames.delete(); frame_rises.delete();
    xn = 32'h0020_0000; yn = 32'h0; sel = 1'b0;
    pulse(1'b1);
    @(negedge clk);
    n_cmp++; if (ovr_a !== 1'b0) begin n_bad++; $display("FAIL ovr_first: got %b want 0", ovr_a); end
    xn = 32'hFD80_0000; yn = 32'h0500_0000;
    pulse(1'b1);
    @(negedge clk);
    n_cmp++; if (ovr_a !== 1'b1) begin n_bad++; $display("FAIL ovr_second: got %b want 1", ovr_a); end
    repeat (3) begin
      pulse(1'b1);
      @(negedge clk);
    end
    wait_idle(1'b0, n);
    n_cmp++; if (ovr_a !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", ovr_a); end
    n_cmp++; if (frames.size() != 2) begin n_bad++; $display("FAIL ovr_count: got %0d want 2", frames.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < frames.size()) begin
        n_cmp++; if (frames[i] !== exp[i]) begin n_bad++; $display("FAIL ovr_word%0d: got %h want %h", i, frames[i], exp[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    int k;
    logic [15:0] exp [2];
    exp = '{16'h3900, 16'hB780};
    frames.delete(); frame_rises.delete();
    xn = 32'h0020_0000; yn = 32'h0; sel = 1'b0;
    pulse(1'b1);
    k = 0;
    @(posedge clk);
    while (rises != 9 && k < Limit) begin
      k++;
      @(posedge clk);
    end
    n_cmp++; if (rises != 9) begin n_bad++; $display("FAIL mid_reach_bit7: got %0d rises want 9", rises); end
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cs_n_a !== 1'b1) begin n_bad++; $display("FAIL mid_cs_n: got %b want 1", cs_n_a); end
    n_cmp++; if (sclk_a !== 1'b0) begin n_bad++; $display("FAIL mid_sclk: got %b want 0", sclk_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy_a); end
    n_cmp++; if (ovr_a !== 1'b0) begin n_bad++; $display("FAIL mid_ovr: got %b want 0", ovr_a); end
    @(posedge clk); #1;
    rst = 1'b0;
    xn = 32'h0040_0000; zn = 32'hFFE0_0000; yn = 32'h0500_0000; sel = 1'b1;
    pulse(1'b1);
    @(negedge clk);
    wait_idle(1'b0, n);
    n_cmp++; if (n != UpdA) begin n_bad++; $display("FAIL mid_len: got %0d want %0d", n, UpdA); end
    n_cmp++; if (frames.size() != 2) begin n_bad++; $display("FAIL mid_count: got %0d want 2", frames.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < frames.size()) begin
        n_cmp++; if (frames[i] !== exp[i]) begin n_bad++; $display("FAIL mid_word%0d: got %h want %h", i, frames[i], exp[i]); end
        n_cmp++; if (frame_rises[i] != 16) begin n_bad++; $display("FAIL mid_rises%0d: got %0d want 16", i, frame_rises[i]); end
      end
    end
  endtask

  task automatic test_decim();
    int n;
    logic en_seq [6];
    logic cs_seq [6];
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      for (int p = 1; p <= 4; p++) begin
        pulse(1'b1);
        @(negedge clk);
        n_cmp++;
        if (cs_n_b !== ((p == 4) ? 1'b0 : 1'b1)) begin
          n_bad++; $display("FAIL decim_g%0d_p%0d: got cs_n %b want %b", g, p, cs_n_b, (p != 4));
        end
      end
      wait_idle(1'b1, n);
      n_cmp++; if (n != UpdB) begin n_bad++; $display("FAIL decim_len_g%0d: got %0d want %0d", g, n, UpdB); end
    end
    // Strobes with enable low must not advance the count.
    en_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    cs_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int p = 0; p < 6; p++) begin
      pulse(en_seq[p]);
      @(negedge clk);
      n_cmp++;
      if (cs_n_b !== cs_seq[p]) begin
        n_bad++; $display("FAIL decim_en_p%0d: got cs_n %b want %b", p, cs_n_b, cs_seq[p]);
      end
    end
    wait_idle(1'b1, n);
    n_cmp++; if (ovr_b !== 1'b0) begin n_bad++; $display("FAIL decim_ovr: got %b want 0", ovr_b); end
  endtask

  task automatic test_mode0();
    n_cmp++; if (mode0_bad != 0) begin n_bad++; $display("FAIL mode0_timing: got %0d violations want 0", mode0_bad); end
    n_cmp++; if (gap_bad != 0) begin n_bad++; $display("FAIL mode0_gap: got %0d short gaps want 0", gap_bad); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_saturate();
    test_overrun();
    test_reset_midframe();
    test_decim();
    test_mode0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
